// File: rtl/cve2_counter.sv
// Performance/timer counter for the CSR file (mcycle, minstret, mhpmcounterN).
// Stores CounterWidth bits and presents a zero-extended 64-bit value. Each
// 32-bit half is CSR-writable, and the counter increments on an event strobe.

module cve2_counter #(
    parameter int unsigned CounterWidth  = 32,
    parameter bit          ProvideValUpd = 1'b0,
    parameter logic [63:0] ResetValue    = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        counter_inc_i,
    input  logic        counter_we_i,
    input  logic        counterh_we_i,
    input  logic [31:0] counter_val_i,
    output logic [63:0] counter_o,
    output logic [63:0] counter_val_upd_o,
    output logic        overflow_o
);

    logic [CounterWidth-1:0] counter_q, counter_d;
    logic                    overflow_q, overflow_d;
    logic [63:0]             counter_ext;
    logic [63:0]             counter_inc_ext;
    logic [63:0]             counter_next_ext;
    logic [63:0]             counter_upd_ext;
    logic                    unused_bits;

    // Zero-extended view plus one 64-bit adder, so carry crosses the 32-bit boundary.
    always_comb begin
        counter_ext                   = '0;
        counter_ext[CounterWidth-1:0] = counter_q;
        counter_inc_ext               = counter_ext + 64'd1;
        counter_upd_ext                   = '0;
        counter_upd_ext[CounterWidth-1:0] = counter_inc_ext[CounterWidth-1:0];
    end

    // Next value: writes take priority over the increment; bits above the width are dropped.
    always_comb begin
        counter_next_ext = counter_ext;
        overflow_d       = 1'b0;
        if (counter_we_i && counterh_we_i) begin
            counter_next_ext = {counter_val_i, counter_val_i};
        end else if (counter_we_i) begin
            counter_next_ext[31:0] = counter_val_i;
        end else if (counterh_we_i) begin
            counter_next_ext[63:32] = counter_val_i;
        end else if (counter_inc_i) begin
            counter_next_ext = counter_inc_ext;
            // Only an increment from all-ones wraps; writes never flag overflow.
            overflow_d       = &counter_q;
        end
        counter_d = counter_next_ext[CounterWidth-1:0];
    end

    // Counter and overflow pulse registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            counter_q  <= ResetValue[CounterWidth-1:0];
            overflow_q <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            overflow_q <= overflow_d;
        end
    end

    assign counter_o         = counter_ext;
    assign counter_val_upd_o = ProvideValUpd ? counter_upd_ext : 64'd0;
    assign overflow_o        = overflow_q;

    // Upper bits are unused for narrow widths.
    assign unused_bits = ^{counter_next_ext, counter_inc_ext};

    // Write enables come from the CSR decode and must never be X out of reset.
    we_known_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !$isunknown({counter_we_i, counterh_we_i}));

endmodule

// File: tb/tb_cve2_counter.sv
// Scoreboard bench for cve2_counter: three instances with different widths and options.
// Stimulus pushes expected values; a monitor drains and compares them mid-cycle.

module tb_cve2_counter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        inc   [3];
    logic        we    [3];
    logic        hwe   [3];
    logic [31:0] val   [3];
    logic [63:0] cnt   [3];
    logic [63:0] upd   [3];
    logic        ovf   [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          dut;
        string       name;
        logic [63:0] cnt;
        logic        ovf;
        logic [63:0] upd;
    } exp_t;

    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    // dut 0: 64-bit with update output; dut 1: 8-bit; dut 2: 64-bit, no update, reset 7
    cve2_counter #(.CounterWidth(64), .ProvideValUpd(1'b1), .ResetValue(64'h0)) u_d0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .counter_inc_i(inc[0]), .counter_we_i(we[0]),
        .counterh_we_i(hwe[0]), .counter_val_i(val[0]), .counter_o(cnt[0]),
        .counter_val_upd_o(upd[0]), .overflow_o(ovf[0])
    );
    cve2_counter #(.CounterWidth(8), .ProvideValUpd(1'b1), .ResetValue(64'h0)) u_d1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .counter_inc_i(inc[1]), .counter_we_i(we[1]),
        .counterh_we_i(hwe[1]), .counter_val_i(val[1]), .counter_o(cnt[1]),
        .counter_val_upd_o(upd[1]), .overflow_o(ovf[1])
    );
    cve2_counter #(.CounterWidth(64), .ProvideValUpd(1'b0), .ResetValue(64'd7)) u_d2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .counter_inc_i(inc[2]), .counter_we_i(we[2]),
        .counterh_we_i(hwe[2]), .counter_val_i(val[2]), .counter_o(cnt[2]),
        .counter_val_upd_o(upd[2]), .overflow_o(ovf[2])
    );

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            inc[i] = 1'b0;
            we[i]  = 1'b0;
            hwe[i] = 1'b0;
            val[i] = 32'd0;
        end
    endtask

    // Drive one DUT's inputs just after the falling edge.
    task automatic apply(input int d, input logic i, input logic w, input logic h,
                         input logic [31:0] v);
        @(negedge clk_i);
        clear_inputs();
        inc[d] = i;
        we[d]  = w;
        hwe[d] = h;
        val[d] = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic expect_st(input int d, input string n, input logic [63:0] c, input logic o,
                             input logic [63:0] u);
        exp_t e;
        e.dut  = d;
        e.name = n;
        e.cnt  = c;
        e.ovf  = o;
        e.upd  = u;
        sb.push_back(e);
    endtask

    task automatic step(input int d, input logic i, input logic w, input logic h,
                        input logic [31:0] v, input string n, input logic [63:0] c,
                        input logic o, input logic [63:0] u);
        apply(d, i, w, h, v);
        tick();
        expect_st(d, n, c, o, u);
    endtask

    task automatic cmp(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    // Monitor: compare every pending expectation two time units after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({e.name, ".cnt"}, cnt[e.dut], e.cnt);
                cmp({e.name, ".ovf"}, {63'd0, ovf[e.dut]}, {63'd0, e.ovf});
                cmp({e.name, ".upd"}, upd[e.dut], e.upd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        #1;
        expect_st(0, "rst_d0", 64'd0, 1'b0, 64'd1);
        expect_st(1, "rst_d1", 64'd0, 1'b0, 64'd1);
        expect_st(2, "rst_d2", 64'd7, 1'b0, 64'd0);
        #12 rst_ni = 1'b1;

        // 64-bit: carry across the halves
        step(0, 0, 1, 0, 32'hFFFF_FFFF, "lo_wr", 64'h0000_0000_FFFF_FFFF, 0, 64'h1_0000_0000);
        step(0, 0, 0, 1, 32'h0000_0001, "hi_wr", 64'h0000_0001_FFFF_FFFF, 0, 64'h2_0000_0000);
        step(0, 1, 0, 0, 32'd0, "carry", 64'h0000_0002_0000_0000, 0, 64'h2_0000_0001);
        // Write beats increment
        step(0, 0, 1, 1, 32'd0, "clr", 64'd0, 0, 64'd1);
        step(0, 0, 1, 0, 32'd10, "ld10", 64'd10, 0, 64'd11);
        step(0, 1, 1, 0, 32'd5, "we_beats_inc", 64'd5, 0, 64'd6);
        step(0, 1, 0, 1, 32'd3, "hwe_beats_inc", 64'h3_0000_0005, 0, 64'h3_0000_0006);
        // Wrap and overflow pulse
        step(0, 0, 1, 1, 32'hFFFF_FFFF, "ones", 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        step(0, 1, 0, 0, 32'd0, "wrap", 64'd0, 1, 64'd1);
        step(0, 0, 0, 0, 32'd0, "wrap_after", 64'd0, 0, 64'd1);
        // Writing 0 over all-ones must not flag overflow
        step(0, 0, 1, 1, 32'hFFFF_FFFF, "ones2", 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        step(0, 1, 1, 1, 32'd0, "wr0_ones", 64'd0, 0, 64'd1);
        step(0, 0, 0, 0, 32'd0, "wr0_after", 64'd0, 0, 64'd1);
        // Update output is independent of the strobe
        step(0, 0, 1, 0, 32'd41, "ld41", 64'd41, 0, 64'd42);
        apply(0, 1, 0, 0, 32'd0);
        expect_st(0, "upd_inc_hi", 64'd41, 0, 64'd42);
        tick();
        expect_st(0, "inc42", 64'd42, 0, 64'd43);

        // 8-bit instance
        step(1, 0, 1, 0, 32'h0000_01F0, "n_lo_wr", 64'h00F0, 0, 64'h00F1);
        step(1, 1, 0, 1, 32'hFFFF_FFFF, "n_hi_wr", 64'h00F0, 0, 64'h00F1);
        for (int k = 0; k < 14; k++) step(1, 1, 0, 0, 32'd0, "n_inc", 64'h00F1 + 64'(k), 0,
                                           64'h00F2 + 64'(k));
        step(1, 1, 0, 0, 32'd0, "n_ff", 64'h00FF, 0, 64'd0);
        step(1, 1, 0, 0, 32'd0, "n_wrap", 64'd0, 1, 64'd1);
        step(1, 0, 0, 0, 32'd0, "n_wrap_after", 64'd0, 0, 64'd1);
        step(1, 0, 1, 1, 32'h0000_1234, "n_both", 64'h0034, 0, 64'h0035);

        // No update output, reset value 7
        step(2, 1, 0, 0, 32'd0, "u0_inc", 64'd8, 0, 64'd0);
        step(2, 0, 1, 1, 32'hFFFF_FFFF, "u0_ones", 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        apply(2, 1, 0, 0, 32'd0);
        expect_st(2, "u0_mid", 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0);
        tick();
        expect_st(2, "u0_wrap", 64'd0, 1, 64'd0);

        // Asynchronous reset while incrementing
        apply(0, 1, 0, 0, 32'd0);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        expect_st(0, "arst_d0", 64'd0, 0, 64'd1);
        expect_st(1, "arst_d1", 64'd0, 0, 64'd1);
        expect_st(2, "arst_d2", 64'd7, 0, 64'd0);
        @(posedge clk_i);
        #1;
        expect_st(0, "arst_hold", 64'd0, 0, 64'd1);
        @(negedge clk_i);
        #3;
        clear_inputs();
        rst_ni = 1'b1;
        step(0, 1, 0, 0, 32'd0, "post_rst_inc", 64'd1, 0, 64'd2);

        @(negedge clk_i);
        #4;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cve2_counter.md
Name: cve2_counter

Overview:
- Performance/timer counter primitive for the CSR file: mcycle/minstret and mhpmcounterN with their "h" upper halves.
- Receives 32-bit CSR write data from the CSR write-data path, one write enable per half.
- Increments on an event strobe from the core and returns the 64-bit value to the CSR read mux.
- Provides a next-value output so minstret reads in the retiring cycle see the updated count.

Parameters:
- CounterWidth, 32, implemented counter bits (1..64); bits above CounterWidth read as 0 and are not stored.
- ProvideValUpd, 1'b0, when 1 counter_val_upd_o carries the incremented value; when 0 it is tied to 0.
- ResetValue, 64'h0, value loaded at reset, truncated to CounterWidth.

Ports:
- clk_i, input, 1, core clock.
- rst_ni, input, 1, asynchronous active-low reset.
- counter_inc_i, input, 1, increment event for this cycle.
- counter_we_i, input, 1, write enable for bits [31:0].
- counterh_we_i, input, 1, write enable for bits [63:32].
- counter_val_i, input, 32, CSR write data for the selected half.
- counter_o, output, 64, current registered count, zero-extended above CounterWidth.
- counter_val_upd_o, output, 64, counter_o+1 truncated to CounterWidth (combinational), or 0 if ProvideValUpd=0.
- overflow_o, output, 1, one-cycle registered pulse, high the cycle after the count wraps from all-ones to 0.

Behaviour:
- Reset:
  - Asserting rst_ni=0 at any time, including mid-increment or mid-write, immediately forces counter_q=ResetValue[CounterWidth-1:0] and overflow_o=0.
  - counter_val_upd_o follows counter_q.
- Storage: single register counter_q[CounterWidth-1:0]. counter_o = {zeros, counter_q}.
- Next value, evaluated in priority order:
  1. counter_we_i=1 and counterh_we_i=1: both halves are loaded with counter_val_i, i.e. next = {counter_val_i, counter_val_i} truncated.
  2. counter_we_i=1 only: next[31:0]=counter_val_i and next[63:32]=counter_q[63:32]. The increment is dropped that cycle.
  3. counterh_we_i=1 only: next[63:32]=counter_val_i and next[31:0]=counter_q[31:0]. The increment is dropped that cycle.
  4. counter_inc_i=1 with no write: next=counter_q+1, modulo 2^CounterWidth.
  5. Otherwise: hold.
- Width rules:
  - CounterWidth<=32: counterh_we_i has no effect on state, and a high-half write drops the increment in that cycle.
  - Write data bits at or above CounterWidth are discarded.
- Carry propagates across the 32-bit boundary within the single adder. There is no separate half counter.
- Latency: a write or increment is visible on counter_o one cycle after the enable edge.
- counter_val_upd_o:
  - Combinational counter_q+1, independent of counter_inc_i and the write enables.
  - Wraps to 0 when counter_q is all-ones.
- Overflow:
  - overflow_q is set for exactly one cycle when an increment (rule 4) takes counter_q from 2^CounterWidth-1 to 0.
  - Writes never set it, including writing 0 over all-ones.
  - Back-to-back wraps are only possible for small widths; each wrap produces its own pulse.
- counter_we_i and counterh_we_i must be known (not X) whenever rst_ni=1. Check this with known-value assertions.
- No bus handshake: enables are single-cycle strobes qualified by the CSR access decode upstream.

Test Plan:
- Reset check: CounterWidth=64, ResetValue=0.
  - Assert rst_ni low mid-sim while counter_inc_i=1 -> counter_o=0 and overflow_o=0 immediately and asynchronously, with no increment at the next edge.
- Carry across halves: write low=32'hFFFF_FFFF, then high=32'h0000_0001, then one counter_inc_i pulse.
  - Required: counter_o=64'h0000_0001_FFFF_FFFF before the increment, 64'h0000_0002_0000_0000 one cycle after.
- Write beats increment: counter_o=64'd10, assert counter_we_i with counter_val_i=32'd5 and counter_inc_i=1 in the same cycle.
  - Required: counter_o=64'd5 next cycle, not 6 or 11.
- Wrap and overflow: CounterWidth=64, load all-ones via two writes, then pulse counter_inc_i.
  - Required: counter_o=0 and overflow_o=1 for exactly one cycle.
  - Writing 0 over all-ones -> overflow_o stays 0.
- Narrow width: CounterWidth=8.
  - Write counter_val_i=32'h0000_01F0 to the low half -> counter_o=64'h0000_0000_0000_00F0.
  - counterh_we_i with 32'hFFFF_FFFF -> counter_o unchanged.
  - 16 increments -> counter_o=0 with one overflow_o pulse.
- Update output: ProvideValUpd=1, counter_o=64'd41, with counter_inc_i both low and high.
  - Required: counter_val_upd_o=64'd42 in that same cycle.
  - With ProvideValUpd=0: counter_val_upd_o=0 always.
